// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, register-file
// address width, default counter width and the load-use detection helper.
package hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_MEM_DONE = 2'd3
    } state_e;

    // Load in EX writes a register that the instruction in ID reads; r0 never hazards.
    function automatic logic is_load_use(
        input logic                  ex_mem_read,
        input logic [REG_ADDR_W-1:0] ex_rt,
        input logic [REG_ADDR_W-1:0] id_rs,
        input logic [REG_ADDR_W-1:0] id_rt
    );
        return ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller. The controller
// takes the slave view; the pipeline (or a testbench) drives the master view.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic                  start_i;
    logic [REG_ADDR_W-1:0] ID_rsAddr_i;
    logic [REG_ADDR_W-1:0] ID_rtAddr_i;
    logic [REG_ADDR_W-1:0] EX_rtAddr_i;
    logic                  EX_memRead_i;
    logic                  ID_branchTaken_i;
    logic                  MEM_memReq_i;
    logic                  dmem_hit_i;
    logic                  dmem_ack_i;

    logic                  PC_write_o;
    logic                  IF_ID_write_o;
    logic                  IF_ID_flush_o;
    logic                  ID_EX_bubble_o;
    logic                  pipe_stall_o;
    logic                  timeout_err_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport slave (
        input  start_i, ID_rsAddr_i, ID_rtAddr_i, EX_rtAddr_i, EX_memRead_i,
               ID_branchTaken_i, MEM_memReq_i, dmem_hit_i, dmem_ack_i,
        output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
               pipe_stall_o, timeout_err_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output start_i, ID_rsAddr_i, ID_rtAddr_i, EX_rtAddr_i, EX_memRead_i,
               ID_branchTaken_i, MEM_memReq_i, dmem_hit_i, dmem_ack_i,
        input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
               pipe_stall_o, timeout_err_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Enable-driven up counter that sticks at all-ones instead of wrapping.
module sat_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, holding once every bit is set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-memory miss stall FSM with timeout,
// load-use bubble insertion, taken-branch flush and statistics counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    hazard_ctrl_if.slave bus
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic               r_timeout_err;

    logic               w_miss;
    logic               w_load_use;
    logic               w_stall;
    logic               w_stall_evt;
    logic               w_flush;
    logic [CNT_W-1:0]   w_stall_cnt;
    logic [CNT_W-1:0]   w_flush_cnt;

    // MEM_DONE deliberately skips the hit check so the refilled access retires.
    assign w_miss      = (r_state == ST_RUN) && bus.MEM_memReq_i && !bus.dmem_hit_i;
    assign w_load_use  = is_load_use(bus.EX_memRead_i, bus.EX_rtAddr_i,
                                     bus.ID_rsAddr_i, bus.ID_rtAddr_i);
    assign w_stall     = (r_state == ST_IDLE) || (r_state == ST_MEM_WAIT) || w_miss;
    assign w_stall_evt = (r_state != ST_IDLE) && (w_stall || w_load_use);

    // State sequencing, miss timer and sticky timeout flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_miss) begin
                        r_state <= ST_MEM_WAIT;
                        r_timer <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    // Ack is checked first so an ack on the final cycle avoids the error.
                    if (bus.dmem_ack_i) begin
                        r_state <= ST_MEM_DONE;
                    end else if (r_timer == TMR_LAST) begin
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_MEM_DONE: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Priority: stall freezes everything, then load-use bubble, then branch flush.
    always_comb begin
        bus.PC_write_o     = 1'b0;
        bus.IF_ID_write_o  = 1'b0;
        bus.IF_ID_flush_o  = 1'b0;
        bus.ID_EX_bubble_o = 1'b0;
        w_flush            = 1'b0;
        if (!w_stall) begin
            if (w_load_use) begin
                bus.ID_EX_bubble_o = 1'b1;
            end else begin
                bus.PC_write_o    = 1'b1;
                bus.IF_ID_write_o = 1'b1;
                w_flush           = bus.ID_branchTaken_i;
                bus.IF_ID_flush_o = bus.ID_branchTaken_i;
            end
        end
    end

    assign bus.pipe_stall_o  = w_stall;
    assign bus.timeout_err_o = r_timeout_err;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_stall_evt),
        .cnt_o (w_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_flush),
        .cnt_o (w_flush_cnt)
    );

    assign bus.stall_cnt_o = w_stall_cnt;
    assign bus.flush_cnt_o = w_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Control outputs are checked as the packed
// vector {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_stall}.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(16)) bus  ();
    hazard_ctrl_if #(.CNT_W(3))  sbus ();

    hazard_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    hazard_ctrl #(.TIMEOUT_CYCLES(255), .CNT_W(3)) dut_sat (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (sbus.slave)
    );

    localparam logic [4:0] CTL_STALL  = 5'b00001;
    localparam logic [4:0] CTL_NORMAL = 5'b11000;
    localparam logic [4:0] CTL_BUBBLE = 5'b00010;
    localparam logic [4:0] CTL_FLUSH  = 5'b11100;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {bus.PC_write_o, bus.IF_ID_write_o, bus.IF_ID_flush_o,
               bus.ID_EX_bubble_o, bus.pipe_stall_o};
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic clr_inputs;
        bus.start_i          = 1'b0;
        bus.ID_rsAddr_i      = '0;
        bus.ID_rtAddr_i      = '0;
        bus.EX_rtAddr_i      = '0;
        bus.EX_memRead_i     = 1'b0;
        bus.ID_branchTaken_i = 1'b0;
        bus.MEM_memReq_i     = 1'b0;
        bus.dmem_hit_i       = 1'b0;
        bus.dmem_ack_i       = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        sbus.start_i          = 1'b0;
        sbus.ID_rsAddr_i      = '0;
        sbus.ID_rtAddr_i      = '0;
        sbus.EX_rtAddr_i      = '0;
        sbus.EX_memRead_i     = 1'b0;
        sbus.ID_branchTaken_i = 1'b0;
        sbus.MEM_memReq_i     = 1'b0;
        sbus.dmem_hit_i       = 1'b0;
        sbus.dmem_ack_i       = 1'b0;

        // Reset values
        #2;
        chk_ctl("reset_ctl", CTL_STALL);
        chk("reset_err", 32'(bus.timeout_err_o), 32'd0);
        chk("reset_stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
        chk("reset_flush_cnt", 32'(bus.flush_cnt_o), 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_ctl("idle_stall", CTL_STALL);
        tick();
        bus.start_i = 1'b1;
        #1;
        chk_ctl("idle_start_cycle", CTL_STALL);
        tick();
        bus.start_i = 1'b0;
        #1;
        chk_ctl("run_normal", CTL_NORMAL);
        chk("idle_not_counted", 32'(bus.stall_cnt_o), 32'd0);

        // Load-use on rs
        bus.EX_memRead_i = 1'b1; bus.EX_rtAddr_i = 5'd5; bus.ID_rsAddr_i = 5'd5;
        #1;
        chk_ctl("loaduse_rs", CTL_BUBBLE);
        tick();
        clr_inputs();
        #1;
        chk_ctl("loaduse_one_cycle", CTL_NORMAL);
        chk("loaduse_stall_cnt", 32'(bus.stall_cnt_o), 32'd1);

        // Destination r0 never hazards
        bus.EX_memRead_i = 1'b1; bus.EX_rtAddr_i = 5'd0; bus.ID_rsAddr_i = 5'd0;
        #1;
        chk_ctl("loaduse_r0", CTL_NORMAL);
        tick();
        clr_inputs();
        #1;
        chk("r0_stall_cnt", 32'(bus.stall_cnt_o), 32'd1);

        // Load-use on rt
        bus.EX_memRead_i = 1'b1; bus.EX_rtAddr_i = 5'd7; bus.ID_rtAddr_i = 5'd7;
        bus.ID_rsAddr_i = 5'd9;
        #1;
        chk_ctl("loaduse_rt", CTL_BUBBLE);
        tick();
        clr_inputs();
        #1;
        chk("rt_stall_cnt", 32'(bus.stall_cnt_o), 32'd2);

        // Taken branch alone
        bus.ID_branchTaken_i = 1'b1;
        #1;
        chk_ctl("branch_flush", CTL_FLUSH);
        tick();
        clr_inputs();
        #1;
        chk("branch_flush_cnt", 32'(bus.flush_cnt_o), 32'd1);

        // Taken branch with load-use: bubble wins
        bus.ID_branchTaken_i = 1'b1;
        bus.EX_memRead_i = 1'b1; bus.EX_rtAddr_i = 5'd3; bus.ID_rsAddr_i = 5'd3;
        #1;
        chk_ctl("branch_plus_loaduse", CTL_BUBBLE);
        tick();
        clr_inputs();
        #1;
        chk("bl_flush_cnt", 32'(bus.flush_cnt_o), 32'd1);
        chk("bl_stall_cnt", 32'(bus.stall_cnt_o), 32'd3);

        // Miss at N, ack at N+4, pending branch deferred
        bus.MEM_memReq_i = 1'b1; bus.ID_branchTaken_i = 1'b1;
        #1;
        chk_ctl("miss_N", CTL_STALL);
        for (int i = 1; i <= 3; i++) begin
            tick();
            #1;
            chk_ctl("miss_wait", CTL_STALL);
        end
        tick();
        bus.dmem_ack_i = 1'b1;
        #1;
        chk_ctl("miss_ack_N4", CTL_STALL);
        tick();
        bus.dmem_ack_i = 1'b0;
        #1;
        chk_ctl("mem_done_N5", CTL_FLUSH);
        chk("miss_stall_cnt", 32'(bus.stall_cnt_o), 32'd8);
        tick();
        bus.ID_branchTaken_i = 1'b0;
        #1;
        chk("miss_flush_cnt", 32'(bus.flush_cnt_o), 32'd2);

        // N+6 is RUN: a miss is detected again (timeout scenario starts at M)
        chk_ctl("run_N6_miss_M", CTL_STALL);
        tick();
        bus.MEM_memReq_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
        end
        #1;
        chk("err_low_M8", 32'(bus.timeout_err_o), 32'd0);
        tick();
        #1;
        chk("err_high_M9", 32'(bus.timeout_err_o), 32'd1);
        chk_ctl("wait_M9", CTL_STALL);
        tick();
        #1;
        chk("err_hold_M10", 32'(bus.timeout_err_o), 32'd1);
        bus.dmem_ack_i = 1'b1;
        tick();
        bus.dmem_ack_i = 1'b0;
        #1;
        chk_ctl("late_ack_done", CTL_NORMAL);
        chk("late_ack_err", 32'(bus.timeout_err_o), 32'd1);
        chk("timeout_stall_cnt", 32'(bus.stall_cnt_o), 32'd19);
        tick();

        // Back in RUN: new miss at P, async reset at P+3
        bus.MEM_memReq_i = 1'b1;
        #1;
        chk_ctl("run_after_timeout", CTL_STALL);
        tick();
        bus.MEM_memReq_i = 1'b0;
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk_ctl("async_rst_ctl", CTL_STALL);
        chk("async_rst_err", 32'(bus.timeout_err_o), 32'd0);
        chk("async_rst_stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
        chk("async_rst_flush_cnt", 32'(bus.flush_cnt_o), 32'd0);
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        bus.start_i = 1'b0;
        #1;
        chk_ctl("post_rst_run", CTL_NORMAL);
        chk("post_rst_stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
        chk("post_rst_flush_cnt", 32'(bus.flush_cnt_o), 32'd0);

        // Ack on the last timer cycle wins over the timeout
        bus.MEM_memReq_i = 1'b1;
        tick();
        bus.MEM_memReq_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
        end
        bus.dmem_ack_i = 1'b1;
        tick();
        bus.dmem_ack_i = 1'b0;
        #1;
        chk("ack_at_timeout_err", 32'(bus.timeout_err_o), 32'd0);
        chk_ctl("ack_at_timeout_done", CTL_NORMAL);

        // Saturation on a 3-bit counter: reach 6, then 3 more stall cycles
        sbus.start_i = 1'b1;
        tick();
        sbus.start_i = 1'b0;
        sbus.MEM_memReq_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
        end
        #1;
        chk("sat_pre", 32'(sbus.stall_cnt_o), 32'd6);
        tick();
        #1;
        chk("sat_reach", 32'(sbus.stall_cnt_o), 32'd7);
        tick();
        tick();
        #1;
        chk("sat_hold", 32'(sbus.stall_cnt_o), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of MEM_WAIT cycles without ack before the error flag sets.
REQ-002 SHALL have parameter CNT_W, default 16, the width of each statistics counter.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  level; leaves IDLE when sampled high.
REQ-006 ID_rsAddr_i / ID_rtAddr_i  in  5 each  source registers of the instruction in ID.
REQ-007 EX_rtAddr_i  in  5  destination of the instruction in EX.
REQ-008 EX_memRead_i  in  1  instruction in EX is a load.
REQ-009 ID_branchTaken_i  in  1  branch in ID resolved taken.
REQ-010 MEM_memReq_i  in  1  instruction in MEM accesses data memory.
REQ-011 dmem_hit_i  in  1  same-cycle hit for the current access.
REQ-012 dmem_ack_i  in  1  one-cycle pulse: miss refill complete.
REQ-013 PC_write_o / IF_ID_write_o  out  1 each  PC and IF/ID load enables.
REQ-014 IF_ID_flush_o / ID_EX_bubble_o  out  1 each  zero IF/ID; insert NOP into ID/EX.
REQ-015 pipe_stall_o  out  1  freeze all pipeline registers.
REQ-016 timeout_err_o  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt_o / flush_cnt_o  out  CNT_W each  saturating statistics counters.

Function
REQ-018 FSM SHALL have states IDLE, RUN, MEM_WAIT and MEM_DONE.
REQ-019 Transitions SHALL be: IDLE->RUN on start_i; RUN->MEM_WAIT on MEM_memReq_i && !dmem_hit_i; MEM_WAIT->MEM_DONE on dmem_ack_i; MEM_DONE->RUN unconditionally.
REQ-020 pipe_stall_o SHALL be 1 in IDLE, in MEM_WAIT, and in RUN when MEM_memReq_i && !dmem_hit_i (same cycle as the miss).
REQ-021 In MEM_DONE, pipe_stall_o SHALL be 0 and the hit/miss check SHALL be suppressed, so the refilled access retires.
REQ-022 Load-use SHALL be EX_memRead_i && EX_rtAddr_i!=0 && (EX_rtAddr_i==ID_rsAddr_i || EX_rtAddr_i==ID_rtAddr_i).
REQ-023 On load-use with pipe_stall_o=0: PC_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1, IF_ID_flush_o=0.
REQ-024 On ID_branchTaken_i with no load-use and pipe_stall_o=0: IF_ID_flush_o=1, PC_write_o=1, IF_ID_write_o=1.
REQ-025 With no stall, load-use or flush: PC_write_o=IF_ID_write_o=1, ID_EX_bubble_o=IF_ID_flush_o=0.
REQ-026 Priority SHALL be pipe_stall > load-use > flush. When pipe_stall_o=1, all four control outputs are 0 and a pending flush is deferred until release.
REQ-027 Timer: cleared on entry to MEM_WAIT and incremented each MEM_WAIT cycle. After TIMEOUT_CYCLES cycles without ack, timeout_err_o=1 from the next cycle, sticky; FSM stays in MEM_WAIT.
REQ-028 An ack in the same cycle as timeout SHALL win: no error, go to MEM_DONE.
REQ-029 stall_cnt_o SHALL increment on each non-IDLE cycle with pipe_stall_o or load-use; flush_cnt_o on each IF_ID_flush_o cycle. Both saturate at all-ones.
REQ-030 All control outputs SHALL be combinational from the FSM state and inputs; zero-cycle latency.

Reset
REQ-031 rst_i SHALL immediately force state IDLE, timer 0, both counters 0, timeout_err_o=0, including mid-MEM_WAIT.
REQ-032 Reset output values SHALL be: PC_write_o=0, IF_ID_write_o=0, IF_ID_flush_o=0, ID_EX_bubble_o=0, pipe_stall_o=1.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the register-address width (5) and CNT_W's default.
REQ-034 A single sub-module sat_counter (enable, CNT_W-wide, saturating) SHALL be instantiated twice.

Verification
REQ-035 Load-use: EX_memRead=1, EX_rt=5, ID_rs=5 -> PC_write=0, IF_ID_write=0, bubble=1 for exactly that cycle, stall_cnt+1; repeat with EX_rt=0 -> no stall.
REQ-036 Branch taken alone -> flush=1, flush_cnt+1; branch taken plus load-use in the same cycle -> flush=0, bubble=1.
REQ-037 Miss at cycle N, ack at N+4 -> pipe_stall_o=1 for N..N+4, 0 at N+5 (MEM_DONE), RUN at N+6, stall_cnt+5.
REQ-038 TIMEOUT_CYCLES=8, miss at N, no ack -> timeout_err_o rises at N+9 and holds; a later ack returns the FSM to RUN with the error still set.
REQ-039 rst_i asserted asynchronously at N+3 of a miss -> outputs take reset values before the next edge; after release with start_i=1, RUN and counters at 0.
REQ-040 Force stall_cnt to all-ones minus 1, apply 3 stall cycles -> holds at all-ones.
